lcd_cam_framebuf: RTL and testbench
===================================

Name: lcd_cam_framebuf

Overview:
Parametrised successor of the camera-to-LCD single-frame display block. It captures greyscale camera pixels into an on-chip frame buffer of configurable size and depth. It generates complete RGB-LCD timing (HSYNC/VSYNC/DE) and shows the stored image in a configurable window, black elsewhere. It adds single-shot/continuous capture modes, short-frame truncation, a frame-valid flag and a fixed pipeline alignment. It sits between the camera interface and the LCD pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_PULSE, 1, HSYNC low width (clocks)
H_BP, 182, horizontal back porch
H_FP, 210, horizontal front porch
V_ACTIVE, 480, visible lines
V_PULSE, 5, VSYNC low width (lines)
V_BP, 0, vertical back porch
V_FP, 45, vertical front porch
IMG_W, 640, stored image width
IMG_H, 294, stored image height
PIX_BITS, 4, stored bits per pixel (1..8, taken from pixdata MSBs)
WIN_X, 80, window left edge within the active area
WIN_Y, 150, window top edge within the active area
CONTINUOUS, 1, 1 = re-arm after every frame; 0 = single-shot

Ports:
PixelClk  in  1  sole clock (camera and LCD domain)
reset  in  1  synchronous, active-high
pixdata  in  8  camera luma
vsync  in  1  camera frame sync, high between frames
hsync  in  1  camera line-valid, high = pixdata valid
capture_req  in  1  single-shot trigger (ignored when CONTINUOUS=1)
LCD_DE  out  1  data enable
LCD_HSYNC  out  1  active-low
LCD_VSYNC  out  1  active-low
LCD_R  out  5
LCD_G  out  6
LCD_B  out  5
frame_valid  out  1  buffer holds a complete frame
busy  out  1  capture in progress

Behaviour:
- Reset values: LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0, frame_valid=0, busy=0, counters=0, write address=0. After reset the FSM enters ARM if CONTINUOUS=1, otherwise IDLE.
- Totals: H_TOTAL = H_PULSE+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_PULSE+V_BP+V_ACTIVE+V_FP.
- Counter hc runs 0..H_TOTAL-1 and wraps. vc increments when hc wraps and itself wraps at V_TOTAL-1.
- HSYNC is low for hc<H_PULSE. VSYNC is low for vc<V_PULSE.
- DE is high for hc in [H_PULSE+H_BP, H_PULSE+H_BP+H_ACTIVE-1] and vc in [V_PULSE+V_BP, V_PULSE+V_BP+V_ACTIVE-1].
- Active coordinates: ax = hc-(H_PULSE+H_BP), ay = vc-(V_PULSE+V_BP).
- In-window condition: ax in [WIN_X, WIN_X+IMG_W-1] and ay in [WIN_Y, WIN_Y+IMG_H-1].
- Read address: row base plus column offset. The row base is incremented by IMG_W once per window line, so no multiplier is used.
- Pipeline: stage 1 registers the read address plus delayed sync/DE/window; stage 2 is the RAM read. All LCD outputs correspond to counter position (hc,vc) exactly 2 clocks later and stay mutually aligned.
- Colour: in-window and frame_valid=1 gives the stored value MSB-replicated to 5/6 bits. Example with PIX_BITS=4, value 0xA: R=10101, G=101010. Otherwise RGB=0, including during blanking.
- Capture FSM:
  - IDLE: if capture_req=1, go to ARM.
  - ARM: wait for a vsync falling edge (previous=1, current=0). Then write address=0, busy=1, go to CAPTURE.
  - CAPTURE: each clock with hsync=1 writes pixdata[7:8-PIX_BITS] at the write address and increments it.
    - Writing address IMG_W*IMG_H-1 → DONE.
    - A vsync rising edge before the full count → DONE (truncated frame). The unwritten remainder keeps its old contents.
  - DONE (1 clock): busy=0, frame_valid=1. Go to ARM if CONTINUOUS=1, else IDLE.
- frame_valid stays 1 once set; only reset clears it.
- Writes never occur outside CAPTURE and never at addresses ≥ IMG_W*IMG_H.
- capture_req while busy is ignored.
- Reset mid-capture: the FSM aborts immediately, frame_valid=0, and the display shows black.
- Frame buffer: inferred simple dual-port RAM, IMG_W*IMG_H × PIX_BITS. Write port on the capture side, read port on the display side, same clock, 1-cycle read latency. A same-address read/write returns the old data.

Test Plan:
- Reset for 3 clocks → HSYNC=VSYNC=1, DE=0, RGB=0, frame_valid=0, busy=0. After release, HSYNC falls at hc=0 and repeats every 1193 clocks; VSYNC period = 530 lines.
- Small config (H_ACTIVE=16, V_ACTIVE=8, IMG_W=4, IMG_H=2, WIN_X=2, WIN_Y=3, PIX_BITS=4, CONTINUOUS=1). Drive vsync 1→0, then 8 hsync-high clocks with pixdata=0x00,0x10..0x70. Response: busy for the capture, frame_valid=1. Display shows R=00000,00010..01110 (MSB-replicated nibbles) at ax=2..5, ay=3..4, 2 clocks after the counters; black elsewhere.
- Truncation: vsync rises after 5 of 8 pixels → DONE, frame_valid=1. Pixels 5..7 keep their prior values; no further writes until the next vsync fall.
- Single-shot (CONTINUOUS=0): with no capture_req, vsync toggles cause no writes and busy stays 0. One capture_req pulse → exactly one frame captured, then IDLE.
- Overflow: 12 hsync-high clocks in the small config → only addresses 0..7 written; extra data is ignored.
- Reset asserted mid-CAPTURE → next clock busy=0, frame_valid=0, RGB=0.

Source files
------------

// File: rtl/lcd_cam_framebuf.sv
// Camera-to-LCD single frame buffer: captures greyscale pixels into an on-chip RAM
// and replays them in a window of a generated RGB-LCD raster, black elsewhere.
module lcd_cam_framebuf #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_PULSE    = 1,
  parameter int unsigned H_BP       = 182,
  parameter int unsigned H_FP       = 210,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_PULSE    = 5,
  parameter int unsigned V_BP       = 0,
  parameter int unsigned V_FP       = 45,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 294,
  parameter int unsigned PIX_BITS   = 4,
  parameter int unsigned WIN_X      = 80,
  parameter int unsigned WIN_Y      = 150,
  parameter int unsigned CONTINUOUS = 1
) (
  input  logic       PixelClk,
  input  logic       reset,
  input  logic [7:0] pixdata,
  input  logic       vsync,
  input  logic       hsync,
  input  logic       capture_req,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic       frame_valid,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_PULSE + H_BP;
  localparam int unsigned V_START = V_PULSE + V_BP;
  localparam int unsigned DEPTH   = IMG_W * IMG_H;
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t              state;
  logic [HW-1:0]       hc;
  logic [VW-1:0]       vc;
  logic [31:0]         hcu, vcu;
  logic                h_act, v_act, h_win, v_win, line_end;
  logic [AW-1:0]       col, row_base, rd_addr, wr_addr;
  logic [PIX_BITS-1:0] mem [DEPTH];
  logic [PIX_BITS-1:0] rd_data;
  logic                we, vs_prev;
  logic                s1_de, s1_hs, s1_vs, s1_win, win2, show;
  logic [5:0]          rep;

  assign hcu      = 32'(hc);
  assign vcu      = 32'(vc);
  assign line_end = (hcu == H_TOTAL - 1);
  assign h_act    = (hcu >= H_START) && (hcu < H_START + H_ACTIVE);
  assign v_act    = (vcu >= V_START) && (vcu < V_START + V_ACTIVE);
  assign h_win    = (hcu >= H_START + WIN_X) && (hcu < H_START + WIN_X + IMG_W);
  assign v_win    = (vcu >= V_START + WIN_Y) && (vcu < V_START + WIN_Y + IMG_H);
  assign col      = AW'(hcu - (H_START + WIN_X));

  always_ff @(posedge PixelClk) begin
    if (reset) begin
      hc       <= '0;
      vc       <= '0;
      row_base <= '0;
    end else begin
      if (line_end) begin
        hc       <= '0;
        vc       <= (vcu == V_TOTAL - 1) ? '0 : vc + 1'b1;
        // Row base steps by one image line per window line and clears outside it.
        row_base <= v_win ? row_base + AW'(IMG_W) : '0;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Stage 1: address and timing; stage 2: RAM read with timing delayed alongside.
  always_ff @(posedge PixelClk) begin
    if (reset) begin
      rd_addr   <= '0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_win    <= 1'b0;
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      win2      <= 1'b0;
    end else begin
      rd_addr   <= row_base + col;
      s1_de     <= h_act && v_act;
      s1_hs     <= (hcu >= H_PULSE);
      s1_vs     <= (vcu >= V_PULSE);
      s1_win    <= h_win && v_win;
      LCD_DE    <= s1_de;
      LCD_HSYNC <= s1_hs;
      LCD_VSYNC <= s1_vs;
      win2      <= s1_win;
    end
  end

  assign we = (state == CAPTURE) && hsync;

  always_ff @(posedge PixelClk) begin
    if (we) mem[wr_addr] <= pixdata[7 -: PIX_BITS];
    rd_data <= mem[rd_addr];
  end

  always_comb begin
    rep = '0;
    for (int unsigned i = 0; i < 6; i++) rep[5-i] = rd_data[PIX_BITS-1-(i%PIX_BITS)];
  end

  assign show  = win2 && frame_valid;
  assign LCD_R = show ? rep[5:1] : '0;
  assign LCD_G = show ? rep : '0;
  assign LCD_B = show ? rep[5:1] : '0;

  always_ff @(posedge PixelClk) begin
    if (reset) begin
      state       <= (CONTINUOUS != 0) ? ARM : IDLE;
      wr_addr     <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      vs_prev     <= 1'b0;
    end else begin
      vs_prev <= vsync;
      case (state)
        IDLE: if (capture_req) state <= ARM;
        ARM: begin
          if (vs_prev && !vsync) begin
            wr_addr <= '0;
            busy    <= 1'b1;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (hsync) wr_addr <= wr_addr + 1'b1;
          if ((hsync && wr_addr == LAST_ADDR) || (!vs_prev && vsync)) begin
            busy        <= 1'b0;
            frame_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= (CONTINUOUS != 0) ? ARM : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cam_framebuf.sv
// Directed bench: small continuous and single-shot instances plus a default-size
// instance for raster timing; output positions are tracked from reset release.
module tb_lcd_cam_framebuf;

  localparam int FRM = 264;          // small config: 22 clocks x 12 lines
  localparam int ABS = 32'h4000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pixdata = 8'h00;
  logic       vs = 1'b1, hs = 1'b0, req = 1'b0;

  logic s_de, s_hs, s_vs, s_fv, s_busy;
  logic [4:0] s_r, s_b; logic [5:0] s_g;
  logic ss_de, ss_hs, ss_vs, ss_fv, ss_busy;
  logic [4:0] ss_r, ss_b; logic [5:0] ss_g;
  logic d_de, d_hs, d_vs, d_fv, d_busy;
  logic [4:0] d_r, d_b; logic [5:0] d_g;

  int total = 0, bad = 0, cnt = 0;
  logic busy_mid, ss_busy_mid;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= rst ? 0 : cnt + 1;

  lcd_cam_framebuf #(.H_ACTIVE(16), .H_PULSE(1), .H_BP(2), .H_FP(3), .V_ACTIVE(8),
    .V_PULSE(1), .V_BP(1), .V_FP(2), .IMG_W(4), .IMG_H(2), .PIX_BITS(4), .WIN_X(2),
    .WIN_Y(3), .CONTINUOUS(1)) u_small (
    .PixelClk(clk), .reset(rst), .pixdata(pixdata), .vsync(vs), .hsync(hs),
    .capture_req(1'b0), .LCD_DE(s_de), .LCD_HSYNC(s_hs), .LCD_VSYNC(s_vs),
    .LCD_R(s_r), .LCD_G(s_g), .LCD_B(s_b), .frame_valid(s_fv), .busy(s_busy));

  lcd_cam_framebuf #(.H_ACTIVE(16), .H_PULSE(1), .H_BP(2), .H_FP(3), .V_ACTIVE(8),
    .V_PULSE(1), .V_BP(1), .V_FP(2), .IMG_W(4), .IMG_H(2), .PIX_BITS(4), .WIN_X(2),
    .WIN_Y(3), .CONTINUOUS(0)) u_ss (
    .PixelClk(clk), .reset(rst), .pixdata(pixdata), .vsync(vs), .hsync(hs),
    .capture_req(req), .LCD_DE(ss_de), .LCD_HSYNC(ss_hs), .LCD_VSYNC(ss_vs),
    .LCD_R(ss_r), .LCD_G(ss_g), .LCD_B(ss_b), .frame_valid(ss_fv), .busy(ss_busy));

  lcd_cam_framebuf u_def (
    .PixelClk(clk), .reset(rst), .pixdata(pixdata), .vsync(vs), .hsync(hs),
    .capture_req(1'b0), .LCD_DE(d_de), .LCD_HSYNC(d_hs), .LCD_VSYNC(d_vs),
    .LCD_R(d_r), .LCD_G(d_g), .LCD_B(d_b), .frame_valid(d_fv), .busy(d_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int idx, input int md);
    int n;
    n = 0;
    @(negedge clk);
    while (!(cnt >= 2 && ((cnt - 2) % md) == idx) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos_in_budget", 32'(n < 2000), 32'd1);
  endtask

  // Output word {R,G,B} expected for a stored nibble, MSB-replicated by hand.
  function automatic logic [31:0] rgb_of(input logic [3:0] n);
    return 32'({n, n[3], n, n[3:2], n, n[3]});
  endfunction

  // Pixel i sits at column i%4, row i/4 of the window (hc=5.., vc=5..).
  task automatic check_pix(input string tag, input int i, input logic [3:0] n, input bit ss);
    wait_pos((5 + i / 4) * 22 + 5 + i % 4, FRM);
    if (ss) chk(tag, 32'({ss_r, ss_g, ss_b}), rgb_of(n));
    else    chk(tag, 32'({s_r, s_g, s_b}), rgb_of(n));
  endtask

  task automatic send_frame(input int n, input logic [7:0] start, input logic [7:0] step);
    vs = 1'b1; hs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      hs = 1'b1;
      pixdata = 8'(int'(start) + i * int'(step));
      @(negedge clk);
      if (i == 2) begin busy_mid = s_busy; ss_busy_mid = ss_busy; end
    end
    hs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_small", 32'({s_de, s_hs, s_vs, s_r, s_g, s_b, s_fv, s_busy}), 32'h000C0000);
    chk("reset_ss",    32'({ss_de, ss_hs, ss_vs, ss_r, ss_g, ss_b, ss_fv, ss_busy}), 32'h000C0000);
    chk("reset_def",   32'({d_de, d_hs, d_vs, d_r, d_g, d_b, d_fv, d_busy}), 32'h000C0000);
    rst = 1'b0;

    wait_pos(0, ABS);
    chk("hs_low_hc0", 32'(s_hs), 32'd0);
    chk("vs_low_vc0", 32'(s_vs), 32'd0);
    chk("def_hs_low_hc0", 32'(d_hs), 32'd0);
    wait_pos(1, ABS);    chk("hs_high_hc1", 32'(s_hs), 32'd1);
    wait_pos(22, ABS);   chk("vs_high_vc1", 32'(s_vs), 32'd1);
    wait_pos(46, ABS);   chk("de_low_hc2", 32'(s_de), 32'd0);
    wait_pos(47, ABS);   chk("de_high_hc3", 32'(s_de), 32'd1);
    wait_pos(115, ABS);  chk("black_before_valid", 32'({s_de, s_r}), 32'h20);
    wait_pos(263, ABS);  chk("vs_high_last_line", 32'(s_vs), 32'd1);
    wait_pos(264, ABS);  chk("vs_period_264", 32'(s_vs), 32'd0);
    wait_pos(1192, ABS); chk("def_hs_high_1192", 32'(d_hs), 32'd1);
    wait_pos(1193, ABS); chk("def_hs_period_1193", 32'(d_hs), 32'd0);

    // Full frame 0x00,0x10..0x70.
    send_frame(8, 8'h00, 8'h10);
    chk("cap1_busy_mid", 32'(busy_mid), 32'd1);
    chk("cap1_done", 32'({s_busy, s_fv}), 32'd1);
    chk("ss_no_req_busy", 32'(ss_busy_mid), 32'd0);
    chk("ss_no_req_fv", 32'(ss_fv), 32'd0);
    for (int i = 0; i < 8; i++) check_pix("cap1_pix", i, 4'(i), 1'b0);
    wait_pos(114, FRM); chk("left_of_window", 32'({s_de, s_r}), 32'h20);
    wait_pos(119, FRM); chk("right_of_window", 32'({s_de, s_r}), 32'h20);
    wait_pos(159, FRM); chk("below_window", 32'({s_de, s_r}), 32'h20);
    wait_pos(0, FRM);   chk("blank_black", 32'({s_de, s_r, s_g}), 32'h0);

    // Truncated frame: 5 pixels 0x80..0xC0, then stray hsync while vsync is high.
    send_frame(5, 8'h80, 8'h10);
    chk("trunc_done", 32'({s_busy, s_fv}), 32'd1);
    hs = 1'b1; pixdata = 8'hF0;
    repeat (3) @(negedge clk);
    hs = 1'b0;
    for (int i = 0; i < 8; i++)
      check_pix("trunc_pix", i, (i < 5) ? 4'(8 + i) : 4'(i), 1'b0);

    // Single-shot capture of nibbles F..8.
    req = 1'b1; @(negedge clk); req = 1'b0;
    send_frame(8, 8'hF0, 8'hF0);
    chk("ss_busy_mid", 32'(ss_busy_mid), 32'd1);
    chk("ss_done", 32'({ss_busy, ss_fv}), 32'd1);
    for (int i = 0; i < 8; i += 3) check_pix("ss_pix", i, 4'(15 - i), 1'b1);

    // Overflow: 12 pixels 0x30.. ; only the first 8 land. Single-shot stays idle.
    send_frame(12, 8'h30, 8'h10);
    chk("ss_idle_no_busy", 32'(ss_busy_mid), 32'd0);
    for (int i = 0; i < 8; i++) check_pix("ovf_pix", i, 4'(3 + i), 1'b0);
    check_pix("ss_kept_pix", 1, 4'hE, 1'b1);

    // Reset in the middle of a capture.
    vs = 1'b1; repeat (2) @(negedge clk);
    vs = 1'b0; @(negedge clk);
    hs = 1'b1; pixdata = 8'h50;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(s_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cap", 32'({s_busy, s_fv, s_r, s_g, s_b}), 32'd0);
    rst = 1'b0; hs = 1'b0; vs = 1'b1;
    wait_pos(115, ABS);
    chk("black_after_reset", 32'({s_de, s_r, s_g}), 32'h800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
